// File: rtl/vector_lane_sequencer.sv
// Per-lane element sequencer: reads vs1/vs2 element operands, runs them through the ALU, writes vd.
// Two-stage read/execute pipeline at one element per cycle; new instructions wait in IDLE via start_ready.
module vector_lane_sequencer #(
  parameter int LONGEST_LEN      = 64,
  parameter int VECTOR_SIZE      = 8,
  parameter int ENTRY_INDEX_SIZE = 3,
  parameter int REG_INDEX_SIZE   = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_valid,
  output logic                        start_ready,
  input  logic [ENTRY_INDEX_SIZE:0]   vl,
  input  logic [2:0]                  vsew,
  input  logic                        vm,
  input  logic [5:0]                  opcode,
  input  logic [REG_INDEX_SIZE-1:0]   vd_idx,
  input  logic [REG_INDEX_SIZE-1:0]   vs1_idx,
  input  logic [REG_INDEX_SIZE-1:0]   vs2_idx,
  input  logic [VECTOR_SIZE-1:0]      mask_bits,
  output logic                        rd_en,
  output logic [REG_INDEX_SIZE-1:0]   rd_vs1_idx,
  output logic [REG_INDEX_SIZE-1:0]   rd_vs2_idx,
  output logic [ENTRY_INDEX_SIZE-1:0] rd_elem,
  input  logic [LONGEST_LEN-1:0]      rd_vs1_data,
  input  logic [LONGEST_LEN-1:0]      rd_vs2_data,
  output logic [LONGEST_LEN-1:0]      alu_vs1,
  output logic [LONGEST_LEN-1:0]      alu_vs2,
  output logic [5:0]                  alu_opcode,
  output logic [2:0]                  alu_vsew,
  output logic                        alu_vm,
  input  logic [LONGEST_LEN-1:0]      alu_result,
  output logic                        wr_en,
  output logic [REG_INDEX_SIZE-1:0]   wr_vd_idx,
  output logic [ENTRY_INDEX_SIZE-1:0] wr_elem,
  output logic [LONGEST_LEN-1:0]      wr_data,
  output logic                        busy,
  output logic                        done
);

  localparam int CW = ENTRY_INDEX_SIZE + 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(VECTOR_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               rcnt_q, rcnt_d;
  logic [CW-1:0]               len_q, len_d;
  logic [2:0]                  vsew_q, vsew_d;
  logic                        vm_q, vm_d;
  logic [5:0]                  opcode_q, opcode_d;
  logic [REG_INDEX_SIZE-1:0]   vd_q, vd_d;
  logic [REG_INDEX_SIZE-1:0]   vs1_q, vs1_d;
  logic [REG_INDEX_SIZE-1:0]   vs2_q, vs2_d;
  logic [VECTOR_SIZE-1:0]      mask_q, mask_d;
  logic                        ex_vld_q, ex_vld_d;
  logic [ENTRY_INDEX_SIZE-1:0] ex_elem_q, ex_elem_d;

  logic [CW-1:0] len_in;
  logic          rd_issue;
  logic          ex_active;

  assign len_in = (vl > MAX_LEN) ? MAX_LEN : vl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      rcnt_q    <= '0;
      len_q     <= '0;
      vsew_q    <= '0;
      vm_q      <= 1'b0;
      opcode_q  <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      mask_q    <= '0;
      ex_vld_q  <= 1'b0;
      ex_elem_q <= '0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      len_q     <= len_d;
      vsew_q    <= vsew_d;
      vm_q      <= vm_d;
      opcode_q  <= opcode_d;
      vd_q      <= vd_d;
      vs1_q     <= vs1_d;
      vs2_q     <= vs2_d;
      mask_q    <= mask_d;
      ex_vld_q  <= ex_vld_d;
      ex_elem_q <= ex_elem_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    len_d     = len_q;
    vsew_d    = vsew_q;
    vm_d      = vm_q;
    opcode_d  = opcode_q;
    vd_d      = vd_q;
    vs1_d     = vs1_q;
    vs2_d     = vs2_q;
    mask_d    = mask_q;
    ex_vld_d  = 1'b0;
    ex_elem_d = ex_elem_q;
    rd_issue  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          len_d    = len_in;
          vsew_d   = vsew;
          vm_d     = vm;
          opcode_d = opcode;
          vd_d     = vd_idx;
          vs1_d    = vs1_idx;
          vs2_d    = vs2_idx;
          mask_d   = mask_bits;
          rcnt_d   = '0;
          state_d  = (len_in != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (rcnt_q < len_q) begin
          rd_issue  = 1'b1;
          ex_vld_d  = 1'b1;
          ex_elem_d = rcnt_q[ENTRY_INDEX_SIZE-1:0];
          rcnt_d    = rcnt_q + CW'(1);
          if (rcnt_d == len_q) begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are masked by rst so an abort takes effect within the reset cycle itself.
  assign busy        = (state_q != S_IDLE);
  assign start_ready = (state_q == S_IDLE) && !rst;
  assign done        = (state_q == S_DONE) && !rst;

  assign rd_en      = rd_issue && !rst;
  assign rd_elem    = rd_en ? rcnt_q[ENTRY_INDEX_SIZE-1:0] : '0;
  assign rd_vs1_idx = busy ? vs1_q : '0;
  assign rd_vs2_idx = busy ? vs2_q : '0;

  assign alu_vs1    = ex_vld_q ? rd_vs1_data : '0;
  assign alu_vs2    = ex_vld_q ? rd_vs2_data : '0;
  assign alu_opcode = opcode_q;
  assign alu_vsew   = vsew_q;
  assign alu_vm     = vm_q;

  // Masked-off elements still occupy their slot; only the write strobe is suppressed.
  assign ex_active = ex_vld_q && (vm_q || mask_q[ex_elem_q]);
  assign wr_en     = ex_active && !rst;
  assign wr_vd_idx = vd_q;
  assign wr_elem   = ex_elem_q;
  assign wr_data   = ex_vld_q ? alu_result : '0;

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Per-lane element sequencer that drives one VECTOR_ALU instance.
- Accepts one vector arithmetic instruction through a valid/ready handshake.
- Steps through elements 0..vl-1 of the source registers: reads operands from the vector register file (VRF), presents them to the ALU, and writes ALU results back to vd.
- Applies the v0 mask and signals completion to the vector issue stage.

Parameters:
LONGEST_LEN, 64, element datapath width (matches ALU operand/result width)
VECTOR_SIZE, 8, maximum elements per vector register handled by this lane
ENTRY_INDEX_SIZE, 3, log2(VECTOR_SIZE), element index width
REG_INDEX_SIZE, 5, vector register index width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start_valid  input  1  issue stage presents an instruction
start_ready  output  1  sequencer can accept (IDLE)
vl  input  ENTRY_INDEX_SIZE+1  element count
vsew  input  3  element width code (ONE_BYTE..EIGHT_BYTE)
vm  input  1  1 = unmasked, 0 = use mask_bits
opcode  input  6  vector opcode
vd_idx, vs1_idx, vs2_idx  input  REG_INDEX_SIZE each  register indices
mask_bits  input  VECTOR_SIZE  v0 mask, bit i governs element i
rd_en  output  1  VRF read request
rd_vs1_idx, rd_vs2_idx  output  REG_INDEX_SIZE  read register indices
rd_elem  output  ENTRY_INDEX_SIZE  element being read
rd_vs1_data, rd_vs2_data  input  LONGEST_LEN  VRF data, valid the cycle after rd_en
alu_vs1, alu_vs2  output  LONGEST_LEN  ALU operands
alu_opcode  output  6  ALU opcode
alu_vsew  output  3  ALU CUR_VSEW
alu_vm  output  1  ALU vm
alu_result  input  LONGEST_LEN  combinational ALU result
wr_en  output  1  VRF write strobe
wr_vd_idx  output  REG_INDEX_SIZE  destination register
wr_elem  output  ENTRY_INDEX_SIZE  destination element
wr_data  output  LONGEST_LEN  write data (= alu_result)
busy  output  1  not IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active-high, sampled on the rising edge.
- Reset: FSM goes to IDLE.
  - start_ready=1 in IDLE after reset.
  - All other outputs are 0: rd_en, wr_en, busy, done, all index/data/ALU outputs.
  - Internal counters and latched instruction fields clear.
- Reset mid-operation: aborts immediately. No wr_en is asserted in or after the reset cycle. Partial writes already made are not undone.
- Acceptance: when start_valid && start_ready, latch vl, vsew, vm, opcode, indices and mask_bits.
  - Effective length len = min(vl, VECTOR_SIZE).
  - Inputs are ignored outside acceptance.
- FSM states:
  - IDLE: start_ready=1. On accept, go to RUN if len>0, else go to DONE.
  - RUN: each cycle, issue read for element rcnt (rd_en=1, rd_elem=rcnt) while rcnt<len.
    - Any element read in the previous cycle is executed and written this cycle. This gives a 2-stage pipeline with one element per cycle of throughput.
    - Go to DRAIN after issuing element len-1.
  - DRAIN: no read. Execute and write the final element, then go to DONE.
  - DONE: done=1 for exactly one cycle, start_ready=0, busy=1. Next state is IDLE.
- Execute stage (combinational within the cycle):
  - alu_vs1=rd_vs1_data, alu_vs2=rd_vs2_data.
  - alu_opcode, alu_vsew and alu_vm come from the latched fields.
  - wr_data=alu_result, wr_elem = registered index of the element read last cycle, wr_vd_idx = latched vd.
- Masking: element i is active iff vm==1 || mask_bits[i]==1.
  - Active element: wr_en=1.
  - Inactive element: wr_en=0, so vd stays undisturbed. It still consumes its pipeline slot.
- Other rules:
  - rd_vs1_idx/rd_vs2_idx hold the latched values while busy and are 0 in IDLE.
  - Element counters do not wrap. They stop at len.
  - vl > VECTOR_SIZE is clamped to VECTOR_SIZE, with no error.
  - start_valid asserted while busy is not accepted (start_ready=0) and must be held by the issuer.
  - A new instruction can be accepted no earlier than the cycle after done.
- Latency: with acceptance at edge T0, read of element k occurs in cycle T0+1+k, and write of element k occurs in cycle T0+2+k. done is asserted in cycle T0+len+2; for len=0, done is asserted in cycle T0+1.
- Width rule: the sequencer never truncates data. Width selection by vsew is the ALU's job. Data passes through at LONGEST_LEN.

Test Plan:
- Reset then idle: hold rst 2 cycles -> start_ready=1, busy=0, done=0, rd_en=0, wr_en=0.
- Unmasked add: vl=4, vsew=ONE_BYTE, vm=1, opcode=VECTOR_ADD, vd=3, VRF model returns vs1=elem*1, vs2=0x10, ALU model = sum -> wr_en on 4 consecutive cycles, elems 0..3, wr_data 0x10,0x11,0x12,0x13, wr_vd_idx=3; done 1 cycle after last write; then start_ready=1.
- Masked: vl=8, vm=0, mask_bits=8'b1010_0101 -> writes only elems 0,2,5,7; done at T0+10.
- vl=0 -> no rd_en, no wr_en, done at T0+1, back to IDLE at T0+2.
- Clamp and back-pressure: vl=15 (4-bit) -> exactly 8 writes. start_valid held high during busy -> second instruction accepted only in the cycle after done.
- Reset mid-operation: vl=8, assert rst during cycle with wr_elem=3 -> no wr_en in that cycle or after, no done pulse, state IDLE with start_ready=1 in the cycle following reset release.
